// File: rtl/profiler_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : profiler_pkg
//  Description : Shared definitions for the instruction profiler and its
//                snapshot streamer: bank geometry defaults, frame marker,
//                FSM state encoding and frame sizing helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package profiler_pkg;

  localparam int         DEF_NUM_COUNTERS = 10;
  localparam int         DEF_CNT_W        = 32;
  localparam logic [7:0] DEF_HEADER_BYTE  = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HEADER = 3'd1,
    ST_COUNT  = 3'd2,
    ST_DATA   = 3'd3,
    ST_CSUM   = 3'd4
  } state_e;

  // Bytes in one frame: header + count + payload + checksum.
  function automatic int frame_len(input int num_counters, input int cnt_w);
    return num_counters * cnt_w / 8 + 3;
  endfunction

  // Index width that never collapses to zero bits for single-entry ranges.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/profiler_snapshot_streamer_if.sv
`default_nettype none
// ============================================================================
//  Module      : profiler_snapshot_streamer_if
//  Description : Byte stream valid/ready bundle carrying snapshot frames.
//  Revision    : 1.0 - initial release
// ============================================================================
interface profiler_snapshot_streamer_if;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);
endinterface
`default_nettype wire

// File: rtl/profiler_snapshot_bank.sv
`default_nettype none
// ============================================================================
//  Module      : profiler_snapshot_bank
//  Description : Capture registers for the whole counter bank plus the
//                counter/byte select mux that feeds the stream serialiser.
//  Revision    : 1.0 - initial release
// ============================================================================
module profiler_snapshot_bank
  import profiler_pkg::*;
#(
  parameter int NUM_COUNTERS = DEF_NUM_COUNTERS,
  parameter int CNT_W        = DEF_CNT_W,
  localparam int BPC         = CNT_W / 8,
  localparam int CIDX_W      = idx_w(NUM_COUNTERS),
  localparam int BIDX_W      = idx_w(CNT_W / 8)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          capture_i,
  input  logic [NUM_COUNTERS*CNT_W-1:0] counters_i,
  input  logic [CIDX_W-1:0]             cidx_i,
  input  logic [BIDX_W-1:0]             bidx_i,
  output logic [7:0]                    byte_o
);

  // Packed so that [k][b] lands on byte b (LSB first) of counter k.
  logic [NUM_COUNTERS-1:0][BPC-1:0][7:0] snap_q;

  // Atomic one-cycle capture of the full bank.
  always_ff @(posedge clk) begin
    if (rst) begin
      snap_q <= '0;
    end else if (capture_i) begin
      snap_q <= counters_i;
    end
  end

  assign byte_o = snap_q[cidx_i][bidx_i];

endmodule
`default_nettype wire

// File: rtl/profiler_snapshot_streamer.sv
`default_nettype none
// ============================================================================
//  Module      : profiler_snapshot_streamer
//  Description : Snapshots the profiler counter bank on request and streams
//                it out as a framed, XOR-checksummed byte sequence.
//  Revision    : 1.0 - initial release
// ============================================================================
module profiler_snapshot_streamer
  import profiler_pkg::*;
#(
  parameter int         NUM_COUNTERS = DEF_NUM_COUNTERS,
  parameter int         CNT_W        = DEF_CNT_W,
  parameter logic [7:0] HEADER_BYTE  = DEF_HEADER_BYTE
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          snap_req,
  input  logic [NUM_COUNTERS*CNT_W-1:0] counters_in,
  profiler_snapshot_streamer_if.master  strm,
  output logic                          busy,
  output logic [7:0]                    drop_count
);

  localparam int                CIDX_W     = idx_w(NUM_COUNTERS);
  localparam int                BIDX_W     = idx_w(CNT_W / 8);
  localparam logic [CIDX_W-1:0] LAST_CIDX  = CIDX_W'(NUM_COUNTERS - 1);
  localparam logic [BIDX_W-1:0] LAST_BIDX  = BIDX_W'(CNT_W / 8 - 1);
  localparam logic [7:0]        COUNT_BYTE = 8'(NUM_COUNTERS);

  state_e              state_q, state_d;
  logic [CIDX_W-1:0]   cidx_q, cidx_d;
  logic [BIDX_W-1:0]   bidx_q, bidx_d;
  logic [7:0]          csum_q, csum_d;
  logic [7:0]          data_q, data_d;
  logic [7:0]          drop_q, drop_d;
  logic                capture;
  logic                hs;
  logic [7:0]          bank_byte;

  assign hs             = (state_q != ST_IDLE) && strm.out_ready;
  assign strm.out_valid = (state_q != ST_IDLE);
  assign strm.out_data  = data_q;
  assign busy           = (state_q != ST_IDLE);
  assign drop_count     = drop_q;

  // Bank is addressed with next-state indices so out_data can be registered.
  profiler_snapshot_bank #(
    .NUM_COUNTERS (NUM_COUNTERS),
    .CNT_W        (CNT_W)
  ) u_bank (
    .clk        (clk),
    .rst        (rst),
    .capture_i  (capture),
    .counters_i (counters_in),
    .cidx_i     (cidx_d),
    .bidx_i     (bidx_d),
    .byte_o     (bank_byte)
  );

  // State, indices, checksum, output byte and drop counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cidx_q  <= '0;
      bidx_q  <= '0;
      csum_q  <= '0;
      data_q  <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      cidx_q  <= cidx_d;
      bidx_q  <= bidx_d;
      csum_q  <= csum_d;
      data_q  <= data_d;
      drop_q  <= drop_d;
    end
  end

  // Next-state, index walk, capture strobe and saturating drop count.
  always_comb begin
    state_d = state_q;
    cidx_d  = cidx_q;
    bidx_d  = bidx_q;
    capture = 1'b0;
    drop_d  = drop_q;
    if (snap_req && (state_q != ST_IDLE) && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end
    case (state_q)
      ST_IDLE: begin
        if (snap_req) begin
          state_d = ST_HEADER;
          capture = 1'b1;
        end
      end
      ST_HEADER: begin
        if (hs) state_d = ST_COUNT;
      end
      ST_COUNT: begin
        if (hs) begin
          state_d = ST_DATA;
          cidx_d  = '0;
          bidx_d  = '0;
        end
      end
      ST_DATA: begin
        if (hs) begin
          if (bidx_q == LAST_BIDX) begin
            bidx_d = '0;
            if (cidx_q == LAST_CIDX) begin
              state_d = ST_CSUM;
            end else begin
              cidx_d = cidx_q + CIDX_W'(1);
            end
          end else begin
            bidx_d = bidx_q + BIDX_W'(1);
          end
        end
      end
      ST_CSUM: begin
        if (hs) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Running checksum and the byte presented in the upcoming state.
  always_comb begin
    data_d = data_q;
    csum_d = csum_q;
    if (state_q == ST_IDLE) begin
      if (snap_req) begin
        csum_d = '0;
        data_d = HEADER_BYTE;
      end
    end else if (hs) begin
      if (state_q != ST_CSUM) csum_d = csum_q ^ data_q;
      case (state_d)
        ST_COUNT: data_d = COUNT_BYTE;
        ST_DATA:  data_d = bank_byte;
        ST_CSUM:  data_d = csum_q ^ data_q;
        default:  data_d = 8'h00;
      endcase
    end
  end

endmodule
`default_nettype wire
